// File: rtl/fcta_stage_sequencer.sv
// Stage sequencer for an N-layer FC accelerator: walks A0/FP/SOFTMAX/BP/PU stages
// per sample and per batch, handshaking each stage with the datapath's done strobe.
module fcta_stage_sequencer #(
  parameter int unsigned NUM_LAYERS = 4,
  parameter int unsigned LAYER_BW   = 2,
  parameter int unsigned BATCH_BW   = 8,
  parameter int unsigned STAGE_BW   = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic                train_i,
  input  logic [BATCH_BW-1:0] batch_size_i,
  input  logic                abort_i,
  input  logic                stage_done_i,
  output logic [STAGE_BW-1:0] stage_o,
  output logic [LAYER_BW-1:0] layer_o,
  output logic                stage_start_o,
  output logic                busy_o,
  output logic [BATCH_BW-1:0] sample_cnt_o,
  output logic                sample_done_o,
  output logic                batch_done_o
);

  typedef enum logic [STAGE_BW-1:0] {
    ST_IDLE    = STAGE_BW'(0),
    ST_A0      = STAGE_BW'(1),
    ST_FP      = STAGE_BW'(2),
    ST_SOFTMAX = STAGE_BW'(3),
    ST_BPDZ    = STAGE_BW'(4),
    ST_BPDW    = STAGE_BW'(5),
    ST_BPDA    = STAGE_BW'(6),
    ST_PU      = STAGE_BW'(7)
  } stage_t;

  localparam logic [LAYER_BW-1:0] LAST_LAYER = LAYER_BW'(NUM_LAYERS - 1);

  stage_t              stage_q, stage_n;
  logic [LAYER_BW-1:0] layer_q, layer_n;
  logic [BATCH_BW-1:0] cnt_q, cnt_n, cnt_inc;
  logic [BATCH_BW-1:0] batch_q, batch_n;
  logic                train_q, train_n;
  logic                stage_start_q, stage_start_n;
  logic                sample_done_q, sample_done_n;
  logic                batch_done_q, batch_done_n;
  logic                busy_q, busy_n;
  logic                end_sample, advance;

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_q       <= ST_IDLE;
      layer_q       <= '0;
      cnt_q         <= '0;
      batch_q       <= '0;
      train_q       <= 1'b0;
      stage_start_q <= 1'b0;
      sample_done_q <= 1'b0;
      batch_done_q  <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      stage_q       <= stage_n;
      layer_q       <= layer_n;
      cnt_q         <= cnt_n;
      batch_q       <= batch_n;
      train_q       <= train_n;
      stage_start_q <= stage_start_n;
      sample_done_q <= sample_done_n;
      batch_done_q  <= batch_done_n;
      busy_q        <= busy_n;
    end
  end

  // Next-state: start acceptance, abort, per-stage advance and end-of-sample bookkeeping
  always_comb begin
    stage_n       = stage_q;
    layer_n       = layer_q;
    cnt_n         = cnt_q;
    batch_n       = batch_q;
    train_n       = train_q;
    sample_done_n = 1'b0;
    batch_done_n  = 1'b0;
    end_sample    = 1'b0;
    advance       = 1'b0;
    cnt_inc       = cnt_q + BATCH_BW'(1);

    if (stage_q == ST_IDLE) begin
      if (start_i && !abort_i && (batch_size_i != '0)) begin
        stage_n = ST_A0;
        layer_n = '0;
        cnt_n   = '0;
        train_n = train_i;
        batch_n = batch_size_i;
        advance = 1'b1;
      end
    end else if (abort_i) begin
      stage_n = ST_IDLE;
      layer_n = '0;
      cnt_n   = '0;
    end else if (stage_done_i) begin
      advance = 1'b1;
      case (stage_q)
        ST_A0: begin
          stage_n = ST_FP;
          layer_n = '0;
        end
        ST_FP: begin
          if (layer_q == LAST_LAYER) stage_n = ST_SOFTMAX;
          else                       layer_n = layer_q + LAYER_BW'(1);
        end
        ST_SOFTMAX: begin
          if (train_q) stage_n = ST_BPDZ;
          else         end_sample = 1'b1;
        end
        ST_BPDZ: stage_n = ST_BPDW;
        ST_BPDW: begin
          // Layer 0 has no upstream activation gradient to compute
          if (layer_q != '0) stage_n = ST_BPDA;
          else               end_sample = 1'b1;
        end
        ST_BPDA: begin
          stage_n = ST_BPDZ;
          layer_n = layer_q - LAYER_BW'(1);
        end
        ST_PU: begin
          if (layer_q == LAST_LAYER) begin
            stage_n      = ST_IDLE;
            layer_n      = '0;
            cnt_n        = '0;
            batch_done_n = 1'b1;
          end else begin
            layer_n = layer_q + LAYER_BW'(1);
          end
        end
        default: begin
          stage_n = ST_IDLE;
          layer_n = '0;
          cnt_n   = '0;
        end
      endcase

      if (end_sample) begin
        sample_done_n = 1'b1;
        layer_n       = '0;
        if (cnt_inc != batch_q) begin
          stage_n = ST_A0;
          cnt_n   = cnt_inc;
        end else if (train_q) begin
          stage_n = ST_PU;
          cnt_n   = cnt_inc;
        end else begin
          stage_n      = ST_IDLE;
          cnt_n        = '0;
          batch_done_n = 1'b1;
        end
      end
    end

    stage_start_n = advance && (stage_n != ST_IDLE);
    busy_n        = (stage_n != ST_IDLE);
  end

  assign stage_o       = stage_q;
  assign layer_o       = layer_q;
  assign stage_start_o = stage_start_q;
  assign busy_o        = busy_q;
  assign sample_cnt_o  = cnt_q;
  assign sample_done_o = sample_done_q;
  assign batch_done_o  = batch_done_q;

endmodule

// File: tb/tb_fcta_stage_sequencer.sv
// Bench for fcta_stage_sequencer: a 2-layer and a 1-layer instance, checked cycle by
// cycle against an expected stage list built from the per-sample/per-batch ordering rules.
module tb_fcta_stage_sequencer;

  localparam int unsigned LBW = 2;
  localparam int unsigned BBW = 8;
  localparam int unsigned SBW = 3;

  localparam logic [2:0] S_IDLE = 3'd0, S_A0 = 3'd1, S_FP = 3'd2, S_SM = 3'd3,
                         S_BPDZ = 3'd4, S_BPDW = 3'd5, S_BPDA = 3'd6, S_PU = 3'd7;

  // Observed/expected word: {stage[16:14], layer[13:12], ss, sd, bd, busy, cnt[7:0]}
  localparam logic [16:0] PULSE_MASK = 17'h00E00;

  typedef struct {
    bit sel;         // 1 = one-layer instance, 0 = two-layer instance
    bit train;
    int batch;
    int lat;         // extra cycles per stage before done; -1 = random 0..3
    int abort_at;    // entry index to abort at (with done), -1 = none
    int rst_at;      // entry index to assert async reset at, -1 = none
    bit stray;       // pulse start_i mid-batch
    int exp_starts;  // expected stage_start_o pulses, -1 = take from model
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic train = 1'b0;
  logic [BBW-1:0] batch = '0;
  logic abort = 1'b0;
  logic start_v = 1'b0;
  logic done_v = 1'b0;
  bit   sel = 1'b0;

  logic start1, start2, done1, done2;
  logic [SBW-1:0] st1, st2;
  logic [LBW-1:0] ly1, ly2;
  logic ss1, ss2, by1, by2, sd1, sd2, bd1, bd2;
  logic [BBW-1:0] cn1, cn2;
  logic [16:0] obs;

  int n_tests = 0;
  int n_fail  = 0;
  logic [16:0] exp_q[$];

  always #5 clk = ~clk;

  assign start1 = sel & start_v;
  assign done1  = sel & done_v;
  assign start2 = ~sel & start_v;
  assign done2  = ~sel & done_v;

  always_comb begin
    if (sel) obs = {st1, ly1, ss1, sd1, bd1, by1, cn1};
    else     obs = {st2, ly2, ss2, sd2, bd2, by2, cn2};
  end

  fcta_stage_sequencer #(.NUM_LAYERS(1), .LAYER_BW(LBW), .BATCH_BW(BBW), .STAGE_BW(SBW)) u_dut1 (
    .clk(clk), .rst(rst), .start_i(start1), .train_i(train), .batch_size_i(batch),
    .abort_i(abort), .stage_done_i(done1), .stage_o(st1), .layer_o(ly1),
    .stage_start_o(ss1), .busy_o(by1), .sample_cnt_o(cn1), .sample_done_o(sd1),
    .batch_done_o(bd1));

  fcta_stage_sequencer #(.NUM_LAYERS(2), .LAYER_BW(LBW), .BATCH_BW(BBW), .STAGE_BW(SBW)) u_dut2 (
    .clk(clk), .rst(rst), .start_i(start2), .train_i(train), .batch_size_i(batch),
    .abort_i(abort), .stage_done_i(done2), .stage_o(st2), .layer_o(ly2),
    .stage_start_o(ss2), .busy_o(by2), .sample_cnt_o(cn2), .sample_done_o(sd2),
    .batch_done_o(bd2));

  function automatic logic [16:0] mk(input logic [2:0] s, input int l, input bit ss,
                                     input bit sd, input bit bd, input bit by, input int c);
    return {s, 2'(l), ss, sd, bd, by, 8'(c)};
  endfunction

  // Reference ordering: every stage entry of a whole batch, ending with the IDLE entry
  bit pend_sd;
  int done_cnt;
  function automatic void push(input logic [2:0] s, input int l);
    exp_q.push_back(mk(s, l, 1'b1, pend_sd, 1'b0, 1'b1, done_cnt));
    pend_sd = 1'b0;
  endfunction

  function automatic void build(input int nl, input bit tr, input int b);
    exp_q = {};
    pend_sd = 1'b0;
    done_cnt = 0;
    for (int s = 0; s < b; s++) begin
      push(S_A0, 0);
      for (int l = 0; l < nl; l++) push(S_FP, l);
      push(S_SM, nl - 1);
      if (tr) begin
        for (int l = nl - 1; l >= 0; l--) begin
          push(S_BPDZ, l);
          push(S_BPDW, l);
          if (l > 0) push(S_BPDA, l);
        end
      end
      done_cnt++;
      pend_sd = 1'b1;
    end
    if (tr) for (int l = 0; l < nl; l++) push(S_PU, l);
    exp_q.push_back(mk(S_IDLE, 0, 1'b0, pend_sd, 1'b1, 1'b0, 0));
  endfunction

  task automatic check(input string name, input logic [16:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got stage=%0d layer=%0d ss=%b sd=%b bd=%b busy=%b cnt=%0d, expected stage=%0d layer=%0d ss=%b sd=%b bd=%b busy=%b cnt=%0d",
               name, obs[16:14], obs[13:12], obs[11], obs[10], obs[9], obs[8], obs[7:0],
               exp[16:14], exp[13:12], exp[11], exp[10], exp[9], exp[8], exp[7:0]);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int lat, starts, want;
    bit stop;
    build(v.sel ? 1 : 2, v.train, v.batch);
    want = (v.exp_starts < 0) ? exp_q.size() - 1 : v.exp_starts;
    sel = v.sel;
    starts = 0;
    stop = 1'b0;
    @(negedge clk);
    train = v.train;
    batch = 8'(v.batch);
    start_v = 1'b1;
    @(negedge clk);
    start_v = 1'b0;
    train = ~v.train;
    for (int i = 0; i < exp_q.size() && !stop; i++) begin
      check($sformatf("v%0d entry%0d", idx, i), exp_q[i]);
      if (obs[11]) starts++;
      if (exp_q[i][16:14] == S_IDLE) begin
        stop = 1'b1;
      end else if (i == v.rst_at) begin
        #2 rst = 1'b1;
        #1 check($sformatf("v%0d async_reset", idx), mk(S_IDLE, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        check($sformatf("v%0d reset_held", idx), mk(S_IDLE, 0, 0, 0, 0, 0, 0));
        rst = 1'b0;
        stop = 1'b1;
      end else begin
        lat = (v.lat < 0) ? int'($urandom_range(0, 3)) : v.lat;
        for (int k = 0; k <= lat; k++) begin
          if (k > 0) check($sformatf("v%0d hold%0d.%0d", idx, i, k), exp_q[i] & ~PULSE_MASK);
          if (v.stray && k == 0 && (i % 2 == 1)) begin
            start_v = 1'b1;
            batch = 8'd1;
          end
          done_v = (k == lat);
          abort = (k == lat) && (i == v.abort_at);
          @(negedge clk);
          start_v = 1'b0;
          done_v = 1'b0;
          abort = 1'b0;
          batch = 8'(v.batch);
        end
        if (i == v.abort_at) begin
          check($sformatf("v%0d abort_idle", idx), mk(S_IDLE, 0, 0, 0, 0, 0, 0));
          stop = 1'b1;
        end
      end
    end
    // A done strobe while idle must not start anything
    done_v = 1'b1;
    @(negedge clk);
    done_v = 1'b0;
    check($sformatf("v%0d idle_done_ignored", idx), mk(S_IDLE, 0, 0, 0, 0, 0, 0));
    n_tests++;
    if (starts != want) begin
      n_fail++;
      $display("FAIL v%0d stage_start_count: got %0d expected %0d", idx, starts, want);
    end
  endtask

  vec_t vecs[11];

  initial begin
    vec_t rv;
    vecs[0]  = '{0, 1, 1, 0, -1, -1, 0, 11};
    vecs[1]  = '{0, 0, 3, 1, -1, -1, 0, 12};
    vecs[2]  = '{1, 1, 2, -1, -1, -1, 0, 11};
    vecs[3]  = '{0, 1, 1, 0, 5, -1, 0, 6};
    vecs[4]  = '{0, 1, 1, 0, -1, -1, 0, 11};
    vecs[5]  = '{0, 0, 2, -1, -1, -1, 1, 8};
    vecs[6]  = '{0, 1, 1, 2, -1, 2, 0, 3};
    vecs[7]  = '{0, 1, 2, -1, -1, -1, 1, 20};
    vecs[8]  = '{1, 0, 4, -1, -1, -1, 0, 12};
    vecs[9]  = '{0, 1, 3, -1, -1, -1, 0, 29};
    vecs[10] = '{1, 1, 1, 0, 3, -1, 0, 4};

    // Reset state on both instances
    @(negedge clk);
    sel = 1'b0;
    #1 check("reset_l2", mk(S_IDLE, 0, 0, 0, 0, 0, 0));
    sel = 1'b1;
    #1 check("reset_l1", mk(S_IDLE, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    rst = 1'b0;
    sel = 1'b0;

    // Zero-size batch start is dropped
    @(negedge clk);
    train = 1'b1;
    batch = 8'd0;
    start_v = 1'b1;
    @(negedge clk);
    start_v = 1'b0;
    check("zero_batch_start", mk(S_IDLE, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    check("zero_batch_hold", mk(S_IDLE, 0, 0, 0, 0, 0, 0));

    // Abort wins over start in the same idle cycle
    batch = 8'd3;
    start_v = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start_v = 1'b0;
    abort = 1'b0;
    check("abort_beats_start", mk(S_IDLE, 0, 0, 0, 0, 0, 0));

    for (int i = 0; i < 11; i++) run_vec(vecs[i], i);

    // Randomised batches on both instances
    for (int i = 0; i < 6; i++) begin
      rv = '{bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
             int'($urandom_range(1, 4)), -1, -1, -1, bit'($urandom_range(0, 1)), -1};
      run_vec(rv, 100 + i);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
